// File: rtl/tpu_result_collector_if.sv
// Host-side result stream of the TPU result collector: one lane word per beat.
// A beat transfers on a rising edge where out_valid && out_ready; once out_valid rises the
// master holds out_data/out_unit/out_last stable and keeps out_valid high until that transfer.
interface tpu_result_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int UNIT_W     = 1
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [UNIT_W-1:0]     out_unit;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_unit, output out_last,
                  input out_ready);
  modport slave  (input out_valid, input out_data, input out_unit, input out_last,
                  output out_ready);
endinterface

// File: rtl/tpu_result_collector.sv
// Captures TPU relu_out vectors on done pulses into a small FIFO and serialises the
// active lanes of each vector onto the host stream, flagging vectors lost to a full buffer.
module tpu_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 2,
  parameter int DEPTH      = 4,
  localparam int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            done_in,
  input  logic [NUM_UNITS-1:0]            active_in,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] relu_in,
  tpu_result_collector_if.master          res,
  output logic [CW-1:0]                   count,
  output logic                            full,
  output logic                            overflow,
  output logic                            state_dbg
);

  localparam int VW = NUM_UNITS * DATA_WIDTH;
  localparam int EW = NUM_UNITS + VW;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [NUM_UNITS-1:0] mask_q;
  logic [VW-1:0]        data_q;

  logic                 push, pop;
  logic [EW-1:0]        rd_entry;
  logic [NUM_UNITS-1:0] rd_mask;
  logic [VW-1:0]        rd_data;
  logic [UNIT_W-1:0]    first_lane, next_lane;
  logic                 first_last, next_last;

  function automatic logic [UNIT_W-1:0] lowest_from(input logic [NUM_UNITS-1:0] m, input int start);
    logic [UNIT_W-1:0] r;
    r = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (m[i] && i >= start) r = UNIT_W'(i);
    return r;
  endfunction

  function automatic logic any_from(input logic [NUM_UNITS-1:0] m, input int start);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (m[i] && i >= start) r = 1'b1;
    return r;
  endfunction

  // full comes from the registered count, so a pop on the same edge cannot rescue a push.
  assign full      = (count == CW'(DEPTH));
  assign push      = done_in && !clear && !full;
  assign pop       = (state == IDLE) && (count != '0) && !clear;
  assign state_dbg = (state == SEND);

  assign rd_entry   = mem[rd_ptr];
  assign rd_mask    = rd_entry[EW-1 -: NUM_UNITS];
  assign rd_data    = rd_entry[VW-1:0];
  assign first_lane = lowest_from(rd_mask, 0);
  assign first_last = !any_from(rd_mask, int'(first_lane) + 1);
  assign next_lane  = lowest_from(mask_q, int'(res.out_unit) + 1);
  assign next_last  = !any_from(mask_q, int'(next_lane) + 1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {active_in, relu_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      mask_q       <= '0;
      data_q       <= '0;
      res.out_valid <= 1'b0;
      res.out_data  <= '0;
      res.out_unit  <= '0;
      res.out_last  <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      mask_q       <= '0;
      data_q       <= '0;
      res.out_valid <= 1'b0;
      res.out_data  <= '0;
      res.out_unit  <= '0;
      res.out_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (done_in && full) overflow <= 1'b1;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            mask_q <= rd_mask;
            data_q <= rd_data;
            // An all-zero mask is consumed here without producing any beat.
            if (rd_mask != '0) begin
              res.out_valid <= 1'b1;
              res.out_data  <= rd_data[first_lane*DATA_WIDTH +: DATA_WIDTH];
              res.out_unit  <= first_lane;
              res.out_last  <= first_last;
              state         <= SEND;
            end
          end
        end
        SEND: begin
          if (res.out_ready) begin
            if (res.out_last) begin
              res.out_valid <= 1'b0;
              state         <= IDLE;
            end else begin
              res.out_data <= data_q[next_lane*DATA_WIDTH +: DATA_WIDTH];
              res.out_unit <= next_lane;
              res.out_last <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tpu_result_collector.md
Name: tpu_result_collector

Overview:
Receiving end of the TPU result path: captures the per-unit relu_out vector each time the processing core pulses done, buffers whole vectors, and serialises the active lanes to a host-side valid/ready stream, one DATA_WIDTH word per beat. Sits between tensor_processing_unit (relu_out/done/active_units) and the host readback interface. Detects and flags overflow when the core finishes faster than the host drains.

Parameters:
DATA_WIDTH, 16, width of one result word
NUM_UNITS, 2, lanes per result vector (matches core)
DEPTH, 4, result vectors buffered (power of two, >=2)

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
clear  input  1  synchronous flush, active-high
done_in  input  1  one-cycle pulse: relu_in/active_in valid this cycle
active_in  input  NUM_UNITS  lane mask for this vector
relu_in  input  NUM_UNITS*DATA_WIDTH  packed result vector, lane 0 in LSBs
out_valid  output  1  beat available
out_ready  input  1  host accepts beat
out_data  output  DATA_WIDTH  lane result word
out_unit  output  max(1,$clog2(NUM_UNITS))  lane index of out_data
out_last  output  1  final beat of current vector
count  output  $clog2(DEPTH)+1  vectors held in buffer (excl. one in serialiser)
full  output  1  count == DEPTH
overflow  output  1  sticky: a done_in was dropped

Behaviour:
- Reset (reset=0, async): buffer pointers 0, count 0, full 0, overflow 0, out_valid 0, out_data 0, out_unit 0, out_last 0, FSM IDLE. Deassertion synchronous to clk by the environment.
- Capture: on edge with done_in=1, clear=0, full=0: store {active_in, relu_in} at wr_ptr, wr_ptr++ (wraps mod DEPTH), count++.
- done_in while full=1 (full sampled from registered count, even if a pop occurs that same edge): vector dropped, overflow<=1. Overflow cleared only by reset or clear.
- Vector with active_in == 0 is still captured; on load it is popped and discarded, producing no beats.
- FSM IDLE: if count>0, load entry at rd_ptr into serialiser register, rd_ptr++, count--; if mask!=0 go SEND with lane = lowest set bit, else stay IDLE.
- FSM SEND: out_valid=1; out_data = lane word, out_unit = lane, out_last = 1 iff no higher set bit in mask. On out_valid&out_ready: if out_last go IDLE, else lane = next higher set bit. One idle bubble between vectors.
- out_data/out_unit/out_last are registered and stable while out_valid=1 and out_ready=0; out_valid never drops without a handshake (except clear/reset).
- Latency: done_in in cycle N into empty collector -> count=1 in N+1 -> out_valid=1 in cycle N+2.
- Simultaneous capture and pop (not full): count unchanged, both pointers advance.
- clear=1: highest priority over done_in; pointers/count/overflow zeroed, FSM IDLE, out_valid 0 next cycle; in-flight vector discarded.
- Mid-operation reset: same as reset values immediately (async).

Test Plan:
- Single vector: NUM_UNITS=2, active_in=2'b11, relu_in={16'h0005,16'h0003}, out_ready=1 -> beats (unit0,0x0003,last0),(unit1,0x0005,last1), out_valid first high 2 cycles after done_in.
- Sparse mask: active_in=2'b10, relu_in={16'h00AA,16'h0011} -> single beat unit1, 0x00AA, out_last=1; active_in=0 -> no beats, count returns to 0.
- Backpressure: out_ready=0 for 5 cycles during SEND -> out_data/out_unit/out_last unchanged, out_valid held; release -> beat accepted once.
- Overflow: out_ready=0, 6 done_in pulses (DEPTH=4) -> serialiser holds 1, count=4, full=1, 6th dropped, overflow=1; drain yields exactly 5 vectors in capture order.
- Wrap/concurrency: continuous done_in every 3 cycles with out_ready=1 for 20 vectors -> all 40 beats in order, overflow=0, pointers wrap without loss.
- clear mid-SEND and async reset mid-SEND -> out_valid=0 (next cycle / immediately), count=0, overflow=0, subsequent vector delivered normally.
